// File: rtl/memory_arbiter.sv
// Data-priority arbiter that multiplexes I-fetch and data requests onto a single-ported RAM.
// Optional access timeout with abort pulse on err: define ARB_TIMEOUT_EN.
module memory_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    localparam int unsigned CNT_W      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DACC    = 2'd1,
        ST_IACC    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_ram_ren;
    logic                r_ram_wen;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_store;
    logic [CNT_W-1:0]    r_starve;

    logic w_dreq;
    logic w_starved;
    logic w_grant_d;
    logic w_grant_i;
    logic w_in_acc;
    logic w_acc;
    logic w_rerr;
    logic w_done_d;
    logic w_done_i;
    logic w_timeout;

    // Arbitration: data wins unless fetch has waited STARVE_LIMIT data completions
    assign w_dreq    = dREN | dWEN;
    assign w_starved = (STARVE_LIMIT != 0) && iREN && (r_starve == CNT_W'(STARVE_LIMIT));
    assign w_grant_d = w_dreq && !w_starved;
    assign w_grant_i = iREN && !w_grant_d;

    assign w_in_acc = (r_state == ST_DACC) || (r_state == ST_IACC);
    assign w_acc    = (ramstate == RAM_ACCESS);
    assign w_rerr   = (ramstate == RAM_ERROR);

    // Completion is signalled in the ACCESS cycle itself; a reset in that cycle suppresses it
    assign w_done_d = nRST && (r_state == ST_DACC) && w_acc;
    assign w_done_i = nRST && (r_state == ST_IACC) && w_acc;

    assign dwait    = !w_done_d;
    assign iwait    = !w_done_i;
    assign dload    = w_done_d ? ramload : '0;
    assign iload    = w_done_i ? ramload : '0;

    assign ramREN   = r_ram_ren;
    assign ramWEN   = r_ram_wen;
    assign ramaddr  = r_ram_addr;
    assign ramstore = r_ram_store;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_retry;
    logic            r_err;

    assign w_timeout = w_in_acc && !w_acc && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign err       = r_err;

    // Access-time counter; an ERROR retry keeps counting across the re-grant
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_to_cnt <= '0;
            r_retry  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_state == ST_IDLE) begin
                if ((w_grant_d || w_grant_i) && !r_retry) begin
                    r_to_cnt <= '0;
                end
            end else if (w_in_acc) begin
                if (w_acc) begin
                    r_retry <= 1'b0;
                end else if (w_timeout) begin
                    r_err   <= 1'b1;
                    r_retry <= 1'b0;
                end else begin
                    if (w_rerr) begin
                        r_retry <= 1'b1;
                    end
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Grant FSM with latched request fields driving the RAM
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= ST_IDLE;
            r_ram_ren   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_store <= '0;
            r_starve    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!iREN) begin
                        r_starve <= '0;
                    end
                    if (w_grant_d) begin
                        r_state     <= ST_DACC;
                        r_ram_addr  <= daddr;
                        r_ram_store <= dstore;
                        r_ram_wen   <= dWEN;
                        r_ram_ren   <= !dWEN;
                    end else if (w_grant_i) begin
                        r_state    <= ST_IACC;
                        r_ram_addr <= iaddr;
                        r_ram_ren  <= 1'b1;
                        r_ram_wen  <= 1'b0;
                    end
                end
                ST_DACC, ST_IACC: begin
                    if (w_acc) begin
                        r_state   <= ST_RECOVER;
                        r_ram_ren <= 1'b0;
                        r_ram_wen <= 1'b0;
                        if (r_state == ST_IACC) begin
                            r_starve <= '0;
                        end else if (iREN && (r_starve != CNT_W'(STARVE_LIMIT))) begin
                            r_starve <= r_starve + CNT_W'(1);
                        end
                    end else if (w_timeout || w_rerr) begin
                        r_state   <= ST_IDLE;
                        r_ram_ren <= 1'b0;
                        r_ram_wen <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_memory_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          SL = 4;
    localparam int          TO = 8;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN, dREN, dWEN;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dstore, ramload;
    logic [1:0]    ramstate;
    logic          iwait, dwait, ramREN, ramWEN, err;
    logic [DW-1:0] iload, dload, ramstore;
    logic [AW-1:0] ramaddr;

    memory_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .iload(iload), .dwait(dwait),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the RAM (0 none, 1 data, 2 fetch), whether a recovery cycle is due,
    // the latched request, the starvation count and the timeout bookkeeping.
    int            m_owner, m_starve, m_tcnt;
    bit            m_rec, m_wr, m_err, m_retry, m_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_store;
    string         done_log = "";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_starve = 0; m_tcnt = 0;
        m_rec = 0; m_wr = 0; m_err = 0; m_retry = 0;
        m_addr = '0; m_store = '0; m_valid = 1;
    endtask

    // Compare outputs against the model for this cycle, then advance the model past the edge
    task automatic step();
        logic done_d, done_i;
        #1;
        done_d = nRST && (m_owner == 1) && (ramstate == 2'd2);
        done_i = nRST && (m_owner == 2) && (ramstate == 2'd2);
        if (m_valid) begin
            chk("ramREN", 32'(ramREN), 32'((m_owner == 2) || (m_owner == 1 && !m_wr)));
            chk("ramWEN", 32'(ramWEN), 32'(m_owner == 1 && m_wr));
            chk("dwait", 32'(dwait), 32'(!done_d));
            chk("iwait", 32'(iwait), 32'(!done_i));
            chk("dload", dload, done_d ? ramload : 32'h0);
            chk("iload", iload, done_i ? ramload : 32'h0);
            chk("err", 32'(err), 32'(m_err));
            chk("wait_excl", 32'(!iwait && !dwait), 32'h0);
            if (m_owner != 0) chk("ramaddr", ramaddr, m_addr);
            if (m_owner == 1 && m_wr) chk("ramstore", ramstore, m_store);
        end
        if (!dwait) done_log = {done_log, "D"};
        if (!iwait) done_log = {done_log, "I"};
        if (!nRST) begin
            model_reset();
        end else if (m_valid) begin
            m_err = 0;
            if (m_owner != 0) begin
                if (ramstate == 2'd2) begin
                    if (m_owner == 2) m_starve = 0;
                    else if (iREN && m_starve < SL) m_starve++;
                    m_owner = 0; m_rec = 1; m_retry = 0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (m_tcnt == TO - 1) begin
                    m_owner = 0; m_err = 1; m_retry = 0;
                end
`endif
                else begin
                    if (ramstate == 2'd3) begin m_owner = 0; m_retry = 1; end
                    m_tcnt++;
                end
            end else if (m_rec) begin
                m_rec = 0;
            end else begin
                if (!iREN) m_starve = 0;
                if ((dREN || dWEN) && !(iREN && SL != 0 && m_starve == SL)) begin
                    m_owner = 1; m_wr = dWEN; m_addr = daddr; m_store = dstore;
                    if (!m_retry) m_tcnt = 0;
                end else if (iREN) begin
                    m_owner = 2; m_wr = 0; m_addr = iaddr;
                    if (!m_retry) m_tcnt = 0;
                end
            end
        end
    endtask

    task automatic nxt();
        @(negedge CLK);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin step(); nxt(); end
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = 2'd0;
    endtask

    initial begin
        int lbase;
        string tmp;
        m_valid = 0;
        nRST = 0;
        idle_inputs();
        run(2);
        nRST = 1;
        step();
        chk("rst_ramREN", 32'(ramREN), 32'h0);
        chk("rst_ramWEN", 32'(ramWEN), 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_waits", 32'({iwait, dwait}), 32'h3);
        chk("rst_err", 32'(err), 32'h0);
        nxt();

        // Fetch: ACCESS on the 2nd access cycle
        iREN = 1; iaddr = 32'h40;
        step(); nxt();
        ramstate = 2'd1;
        step();
        chk("t1_ren", 32'(ramREN), 32'h1);
        chk("t1_addr", ramaddr, 32'h40);
        chk("t1_iwait_busy", 32'(iwait), 32'h1);
        nxt();
        ramstate = 2'd2; ramload = 32'hDEADBEEF;
        step();
        chk("t1_iwait", 32'(iwait), 32'h0);
        chk("t1_iload", iload, 32'hDEADBEEF);
        nxt();
        iREN = 0; ramstate = 2'd0; ramload = '0;
        step();
        chk("t1_recover_en", 32'({ramREN, ramWEN}), 32'h0);
        chk("t1_recover_iwait", 32'(iwait), 32'h1);
        nxt();
        run(1);

        // Simultaneous write and fetch: data first
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
        step(); nxt();
        ramstate = 2'd2;
        step();
        chk("t2_wen", 32'(ramWEN), 32'h1);
        chk("t2_store", ramstore, 32'h12345678);
        chk("t2_addr", ramaddr, 32'h80);
        chk("t2_dwait", 32'(dwait), 32'h0);
        nxt();
        dWEN = 0; ramstate = 2'd0;
        run(2);
        ramstate = 2'd2;
        step();
        chk("t2_iwait", 32'(iwait), 32'h0);
        chk("t2_iaddr", ramaddr, 32'h44);
        nxt();
        iREN = 0; ramstate = 2'd0;
        run(2);

        // Continuous contention: starvation guard
        done_log = "";
        iREN = 1; dREN = 1; ramstate = 2'd2;
        run(30);
        n_checks++;
        tmp = (done_log.len() >= 10) ? done_log.substr(0, 9) : done_log;
        if (tmp != "DDDDIDDDDI") begin
            n_errors++;
            $display("FAIL grant_order: got %s expected DDDDIDDDDI", tmp);
        end
        idle_inputs();
        run(3);

        // Address change during DACC is ignored
        dREN = 1; daddr = 32'h80;
        step(); nxt();
        daddr = 32'hC0; ramstate = 2'd1;
        step(); chk("t4_hold1", ramaddr, 32'h80); nxt();
        step(); chk("t4_hold2", ramaddr, 32'h80); nxt();
        ramstate = 2'd2;
        step(); chk("t4_done_addr", ramaddr, 32'h80); chk("t4_dwait", 32'(dwait), 32'h0); nxt();
        idle_inputs();
        run(2);

        // ERROR then retry
        lbase = done_log.len();
        iREN = 1; iaddr = 32'h48;
        step(); nxt();
        ramstate = 2'd3;
        step(); chk("t5_err_iwait", 32'(iwait), 32'h1); nxt();
        ramstate = 2'd0;
        step(); chk("t5_idle_en", 32'(ramREN), 32'h0); nxt();
        ramstate = 2'd2; ramload = 32'hA5A5_0001;
        step(); chk("t5_iwait", 32'(iwait), 32'h0); chk("t5_iload", iload, 32'hA5A5_0001); nxt();
        idle_inputs();
        run(2);
        chk("t5_single", 32'(done_log.len() - lbase), 32'h1);

        // Reset during an access cycle
        dWEN = 1; daddr = 32'h100; dstore = 32'h55;
        step(); nxt();
        ramstate = 2'd2; nRST = 0;
        step(); chk("t6_no_done", 32'(dwait), 32'h1); nxt();
        nRST = 1; dWEN = 0; ramstate = 2'd0;
        step(); chk("t6_en_off", 32'({ramREN, ramWEN}), 32'h0); nxt();
        run(1);

`ifdef ARB_TIMEOUT_EN
        // BUSY forever: abort after TO access cycles
        iREN = 1; iaddr = 32'h200; ramstate = 2'd1;
        step(); nxt();
        for (int k = 0; k < TO; k++) begin
            step(); chk("to_wait", 32'({iwait, err}), 32'h2); nxt();
        end
        step(); chk("to_err", 32'(err), 32'h1); chk("to_en", 32'(ramREN), 32'h0); nxt();
        step(); chk("to_err_once", 32'(err), 32'h0); chk("to_regrant", 32'(ramREN), 32'h1); nxt();
        iREN = 0; ramstate = 2'd2;
        run(1);
        idle_inputs();
        run(3);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            int r;
            nRST   = ($urandom_range(0, 299) != 0);
            iREN   = ($urandom_range(0, 9) < 6);
            dREN   = ($urandom_range(0, 9) < 4);
            dWEN   = ($urandom_range(0, 9) < 3);
            iaddr  = $urandom;
            daddr  = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 19);
            ramstate = (r < 8) ? 2'd2 : (r < 15) ? 2'd1 : (r < 18) ? 2'd0 : 2'd3;
            step(); nxt();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
